// File: rtl/adj_osd_overlay.sv
// rtl/adj_osd_overlay.sv - contrast/brightness OSD bar overlay, 2-cycle pixel pipeline.
// Optional OSD_BLEND_EN: unfilled bar background is the input pixel halved instead of solid grey.
module adj_osd_overlay #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int BAR_X0      = 64,
  parameter int BAR_Y0      = 600,
  parameter int BAR_H       = 16,
  parameter int BAR_GAP     = 8,
  parameter int SHOW_FRAMES = 120
) (
  input  logic        clk_74,
  input  logic        rst,
  input  logic        vs_i,
  input  logic        hs_i,
  input  logic        de_i,
  input  logic [23:0] rgb_i,
  input  logic [7:0]  contrast,
  input  logic [7:0]  bright,
  input  logic        upd,
  output logic        vs_o,
  output logic        hs_o,
  output logic        de_o,
  output logic [23:0] rgb_o,
  output logic        osd_active
);

  localparam int TW = $clog2(SHOW_FRAMES + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(SHOW_FRAMES);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  localparam logic [12:0] X_LO  = 13'(BAR_X0);
  localparam logic [12:0] X_HI  = 13'(BAR_X0 + 1024);
  localparam logic [12:0] X_LIM = 13'(H_ACTIVE);
  localparam logic [11:0] YC_LO = 12'(BAR_Y0);
  localparam logic [11:0] YC_HI = 12'(BAR_Y0 + BAR_H);
  localparam logic [11:0] YB_LO = 12'(BAR_Y0 + BAR_H + BAR_GAP);
  localparam logic [11:0] YB_HI = 12'(BAR_Y0 + 2 * BAR_H + BAR_GAP);
  localparam logic [11:0] Y_LIM = 12'(V_ACTIVE);

  typedef enum logic {IDLE, SHOW} state_t;
  typedef enum logic [1:0] {SEL_PASS, SEL_BG, SEL_FILL_C, SEL_FILL_B} sel_t;

  state_t         state;
  logic [TW-1:0]  timer;
  logic [11:0]    x;
  logic [10:0]    y;
  logic           de_q;
  logic           vs_q;
  logic [7:0]     con_q;
  logic [7:0]     bri_q;

  logic           vs1, hs1, de1;
  logic [23:0]    rgb1;
  sel_t           sel1;

  logic           vs_rise;
  logic           de_fall;
  logic [12:0]    xe;
  logic [11:0]    ye;
  logic [12:0]    dx;
  logic           in_x, in_c, in_b;
  logic           fill_c, fill_b;
  sel_t           sel_d;
  logic [23:0]    bg;

  assign vs_rise = vs_i & ~vs_q;
  assign de_fall = de_q & ~de_i;

  // Position counters and frame-stable copies of the adjustment values
  always_ff @(posedge clk_74 or posedge rst) begin
    if (rst) begin
      de_q  <= 1'b0;
      vs_q  <= 1'b0;
      x     <= '0;
      y     <= '0;
      con_q <= '0;
      bri_q <= '0;
    end else begin
      de_q <= de_i;
      vs_q <= vs_i;
      if (de_i) begin
        if (x != 12'hFFF)
          x <= x + 12'd1;
      end else if (de_q) begin
        x <= '0;
      end
      if (vs_rise)
        y <= '0;
      else if (de_fall && y != 11'h7FF)
        y <= y + 11'd1;
      if (vs_rise) begin
        con_q <= contrast;
        bri_q <= bright;
      end
    end
  end

  // A key event always reloads the display timer, even on a vsync edge
  always_ff @(posedge clk_74 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else if (upd) begin
      state <= SHOW;
      timer <= T_LOAD;
    end else if (state == SHOW && vs_rise) begin
      if (timer <= T_ONE) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        timer <= timer - T_ONE;
      end
    end
  end

  assign osd_active = (state == SHOW);

  assign xe = {1'b0, x};
  assign ye = {1'b0, y};
  assign dx = xe - X_LO;

  assign in_x   = (xe >= X_LO) && (xe < X_HI) && (xe < X_LIM);
  assign in_c   = in_x && (ye >= YC_LO) && (ye < YC_HI) && (ye < Y_LIM);
  assign in_b   = in_x && (ye >= YB_LO) && (ye < YB_HI) && (ye < Y_LIM);
  assign fill_c = dx < {3'b000, con_q, 2'b00};
  assign fill_b = dx < {3'b000, bri_q, 2'b00};

  always_comb begin
    sel_d = SEL_PASS;
    if (state == SHOW && de_i) begin
      if (in_c)
        sel_d = fill_c ? SEL_FILL_C : SEL_BG;
      else if (in_b)
        sel_d = fill_b ? SEL_FILL_B : SEL_BG;
    end
  end

  always_ff @(posedge clk_74 or posedge rst) begin
    if (rst) begin
      vs1  <= 1'b0;
      hs1  <= 1'b0;
      de1  <= 1'b0;
      rgb1 <= '0;
      sel1 <= SEL_PASS;
    end else begin
      vs1  <= vs_i;
      hs1  <= hs_i;
      de1  <= de_i;
      rgb1 <= rgb_i;
      sel1 <= sel_d;
    end
  end

`ifdef OSD_BLEND_EN
  assign bg = {1'b0, rgb1[23:17], 1'b0, rgb1[15:9], 1'b0, rgb1[7:1]};
`else
  assign bg = 24'h202020;
`endif

  always_ff @(posedge clk_74 or posedge rst) begin
    if (rst) begin
      vs_o  <= 1'b0;
      hs_o  <= 1'b0;
      de_o  <= 1'b0;
      rgb_o <= '0;
    end else begin
      vs_o <= vs1;
      hs_o <= hs1;
      de_o <= de1;
      case (sel1)
        SEL_BG:     rgb_o <= bg;
        SEL_FILL_C: rgb_o <= 24'hFFFFFF;
        SEL_FILL_B: rgb_o <= 24'hFFFF00;
        default:    rgb_o <= rgb1;
      endcase
    end
  end

endmodule

// File: doc/adj_osd_overlay.md
ADJ_OSD_OVERLAY -- requirements
Module: adj_osd_overlay

Interface
REQ-001 Parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 720, active lines per frame.
REQ-003 Parameter BAR_X0, default 64, first pixel column of both bars.
REQ-004 Parameter BAR_Y0, default 600, first line of the contrast bar.
REQ-005 Parameter BAR_H, default 16, bar height in lines.
REQ-006 Parameter BAR_GAP, default 8, lines between the contrast bar and the brightness bar.
REQ-007 Parameter SHOW_FRAMES, default 120, OSD display time in frames after the last update.
REQ-008 clk_74  input  1  pixel clock; the only clock.
REQ-009 rst  input  1  reset; asynchronous, active-high.
REQ-010 vs_i / hs_i / de_i  input  1 each  video timing from the contrast/brightness stage; vs_i is active-high.
REQ-011 rgb_i  input  24  pixel, {R,G,B}.
REQ-012 contrast / bright  input  8 each  current adjustment values.
REQ-013 upd  input  1  single-cycle pulse on any contrast or brightness key event.
REQ-014 vs_o / hs_o / de_o  output  1 each  timing delayed to match rgb_o.
REQ-015 rgb_o  output  24  pixel with OSD applied.
REQ-016 osd_active  output  1  high while the FSM is in SHOW.

Function
REQ-017 The block SHALL have a fixed latency of 2 clk_74 cycles on vs, hs, de and rgb, with no bubbles.
REQ-018 The pixel counter x (12 bits) SHALL increment on each de_i-high cycle, clear on the de_i falling edge, and saturate at 4095.
REQ-019 The line counter y (11 bits) SHALL increment on each de_i falling edge, clear on the vs_i rising edge, and saturate at 2047.
REQ-020 contrast and bright SHALL be sampled only on the vs_i rising edge into frame-stable registers, so a bar never changes within a frame.
REQ-021 The FSM SHALL have two states, IDLE and SHOW; upd in any state SHALL go to SHOW and load timer = SHOW_FRAMES.
REQ-022 In SHOW, each vs_i rising edge SHALL decrement the timer; the edge that takes it from 1 to 0 SHALL return the FSM to IDLE.
REQ-023 When upd and a vs_i rising edge occur in the same cycle, the reload SHALL win and the timer SHALL NOT decrement.
REQ-024 The contrast region SHALL be y in [BAR_Y0, BAR_Y0+BAR_H) and x in [BAR_X0, BAR_X0+1024).
REQ-025 The brightness region SHALL be the contrast region shifted down by BAR_H+BAR_GAP lines.
REQ-026 In SHOW, inside a region, a pixel with (x-BAR_X0) < 4*value SHALL be filled: contrast 24'hFFFFFF, brightness 24'hFFFF00.
REQ-027 In SHOW, an unfilled pixel inside a region SHALL be the background colour defined in REQ-033/034.
REQ-028 Outside both regions, in IDLE, or when de is low, rgb_o SHALL equal the delayed rgb_i.
REQ-029 A value of 0 SHALL draw no fill; a value of 255 SHALL fill 1020 pixels.
REQ-030 Bar regions extending beyond H_ACTIVE/V_ACTIVE SHALL be clipped implicitly, because x and y never reach those values.

Reset
REQ-031 While rst is high, all outputs SHALL be 0, the FSM SHALL be IDLE, and the timer, x, y and sampled values SHALL be 0.
REQ-032 Deassertion mid-frame SHALL resume pass-through immediately; y SHALL be valid from the next vs_i rising edge.

Configuration
REQ-033 With OSD_BLEND_EN defined, the unfilled background SHALL be the input pixel halved per channel ({R>>1,G>>1,B>>1}).
REQ-034 Without OSD_BLEND_EN, the unfilled background SHALL be solid 24'h202020.

Verification
REQ-035 No upd, 3 frames of 1280x720 ramp -> rgb_o equals rgb_i delayed 2 cycles; osd_active=0.
REQ-036 contrast=64, bright=255, upd pulse, next frame -> line 600 shows px 64..319 = FFFFFF and px 320..1087 = background; line 624 shows px 64..1083 = FFFF00.
REQ-037 upd at frame 0, SHOW_FRAMES=4 -> osd_active falls on the 4th vs_i rising edge; frame 4 is unmodified.
REQ-038 upd coincident with a vs_i rising edge while timer=1 -> stays SHOW with timer=4.
REQ-039 contrast changes 10->200 mid-frame -> the current frame shows 40 px, the next frame shows 800 px.
REQ-040 rst asserted mid-line during SHOW -> outputs 0 asynchronously; after release osd_active=0 and pass-through holds.
